// File: rtl/spiral_header_deframer_if.sv
// Byte-stream input and decoded-header output bundle for the SPIRAL header deframer.
// The master side feeds bytes and consumes headers; the slave side is the deframer.
interface spiral_header_deframer_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] base_address;
    logic [4:0]  phase_entropy_index;
    logic [2:0]  complecount_trace;
    logic [7:0]  fallback_vector;
    logic [3:0]  somatic_coherence;
    logic        verbal_override;
    logic        chk_err;
    logic        fmt_err;
    logic        timeout_err;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    modport master (
        output in_byte, in_valid, hdr_ready,
        input  in_ready, hdr_valid, base_address, phase_entropy_index, complecount_trace,
               fallback_vector, somatic_coherence, verbal_override,
               chk_err, fmt_err, timeout_err, frame_count, err_count
    );

    modport slave (
        input  in_byte, in_valid, hdr_ready,
        output in_ready, hdr_valid, base_address, phase_entropy_index, complecount_trace,
               fallback_vector, somatic_coherence, verbal_override,
               chk_err, fmt_err, timeout_err, frame_count, err_count
    );
endinterface

// File: rtl/spiral_header_deframer.sv
// Sync-hunting deframer for the 9-byte SPIRAL consent header: XOR checksum,
// reserved-bit check, idle timeout, and a held header on a valid/ready handshake.
module spiral_header_deframer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    spiral_header_deframer_if.slave bus
);
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        BODY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      xor_q, xor_d;
    logic [7:0]      idle_q, idle_d;
    logic [7:1][7:0] shadow_q, shadow_d;
    logic [7:1][7:0] hdr_q, hdr_d;
    logic            hdr_valid_q, hdr_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            chk_err_q, chk_err_d;
    logic            fmt_err_q, fmt_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            accept_s;
    logic            drop_s;

    // Reserved bits of byte 7 must be zero for a well-formed header.
    function automatic logic reserved_bad(input logic [7:0] b7);
        return (b7[2:0] != 3'b000);
    endfunction

    assign accept_s = bus.in_valid && in_ready_q;

    // Next-state, frame assembly, validation and counter updates.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xor_d         = xor_q;
        idle_d        = idle_q;
        shadow_d      = shadow_q;
        hdr_d         = hdr_q;
        chk_err_d     = 1'b0;
        fmt_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        frame_count_d = frame_count_q;
        drop_s        = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept_s && (bus.in_byte == SYNC_BYTE)) begin
                    state_d = BODY;
                    idx_d   = 4'd1;
                    xor_d   = SYNC_BYTE;
                    idle_d  = 8'd0;
                end else begin
                    state_d = HUNT;
                end
            end
            BODY: begin
                if (accept_s) begin
                    idle_d = 8'd0;
                    if (idx_q == 4'd8) begin
                        idx_d = 4'd0;
                        xor_d = 8'd0;
                        // Checksum is judged before the reserved bits.
                        if (xor_q != bus.in_byte) begin
                            chk_err_d = 1'b1;
                            drop_s    = 1'b1;
                            state_d   = HUNT;
                        end else if (reserved_bad(shadow_q[7])) begin
                            fmt_err_d = 1'b1;
                            drop_s    = 1'b1;
                            state_d   = HUNT;
                        end else begin
                            hdr_d         = shadow_q;
                            frame_count_d = frame_count_q + 16'd1;
                            state_d       = HOLD;
                        end
                    end else begin
                        shadow_d[idx_q[2:0]] = bus.in_byte;
                        xor_d                = xor_q ^ bus.in_byte;
                        idx_d                = idx_q + 4'd1;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    timeout_err_d = 1'b1;
                    drop_s        = 1'b1;
                    state_d       = HUNT;
                    idle_d        = 8'd0;
                    idx_d         = 4'd0;
                    xor_d         = 8'd0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            HOLD: begin
                if (bus.hdr_ready) begin
                    state_d = HUNT;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HUNT;
                idx_d   = 4'd0;
                xor_d   = 8'd0;
                idle_d  = 8'd0;
            end
        endcase
        err_count_d = (drop_s && (err_count_q != 8'hFF)) ? (err_count_q + 8'd1) : err_count_q;
        hdr_valid_d = (state_d == HOLD);
        in_ready_d  = (state_d != HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            idx_q         <= 4'd0;
            xor_q         <= 8'd0;
            idle_q        <= 8'd0;
            shadow_q      <= '0;
            hdr_q         <= '0;
            hdr_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            chk_err_q     <= 1'b0;
            fmt_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_count_q <= 16'd0;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            idle_q        <= idle_d;
            shadow_q      <= shadow_d;
            hdr_q         <= hdr_d;
            hdr_valid_q   <= hdr_valid_d;
            in_ready_q    <= in_ready_d;
            chk_err_q     <= chk_err_d;
            fmt_err_q     <= fmt_err_d;
            timeout_err_q <= timeout_err_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.in_ready            = in_ready_q;
    assign bus.hdr_valid           = hdr_valid_q;
    assign bus.base_address        = {hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4]};
    assign bus.phase_entropy_index = hdr_q[5][7:3];
    assign bus.complecount_trace   = hdr_q[5][2:0];
    assign bus.fallback_vector     = hdr_q[6];
    assign bus.somatic_coherence   = hdr_q[7][7:4];
    assign bus.verbal_override     = hdr_q[7][3];
    assign bus.chk_err             = chk_err_q;
    assign bus.fmt_err             = fmt_err_q;
    assign bus.timeout_err         = timeout_err_q;
    assign bus.frame_count         = frame_count_q;
    assign bus.err_count           = err_count_q;
endmodule

// File: tb/tb_spiral_header_deframer.sv
// Self-checking bench for spiral_header_deframer: frame table plus hand-written
// timeout, hold, reset and saturation sequences, checked through an event scoreboard.
module tb_spiral_header_deframer;
    localparam int K_GOOD = 0;
    localparam int K_CHK  = 1;
    localparam int K_FMT  = 2;
    localparam int K_TMO  = 3;

    typedef logic [0:8][7:0] frame_t;
    typedef struct {
        frame_t      b;
        int          kind;
        logic [52:0] fields;
    } vec_t;
    typedef struct {
        int          kind;
        logic [52:0] fields;
        logic [15:0] fc;
        logic [7:0]  ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [52:0] last_good;
    logic [15:0] fc_m;
    logic [7:0]  ec_m;
    vec_t   vecs [8];
    frame_t fa, fa_bad, fb;
    logic [52:0] fields_a, fields_b;

    spiral_header_deframer_if bus ();

    spiral_header_deframer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [52:0] pk(input logic [31:0] base, input logic [4:0] pei,
                                       input logic [2:0] ct, input logic [7:0] fbv,
                                       input logic [3:0] sc, input logic vo);
        return {base, pei, ct, fbv, sc, vo};
    endfunction

    function automatic vec_t mk(input frame_t b, input int kind, input logic [52:0] f);
        vec_t v;
        v.b = b;
        v.kind = kind;
        v.fields = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [52:0] f);
        exp_t e;
        if (kind == K_GOOD) begin
            last_good = f;
            fc_m = fc_m + 16'd1;
        end else if (ec_m != 8'hFF) begin
            ec_m = ec_m + 8'd1;
        end
        e.kind = kind;
        e.fields = last_good;
        e.fc = fc_m;
        e.ec = ec_m;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_wait", 64'(n), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t b);
        for (int i = 0; i < 9; i++) send_byte(b[i]);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        last_good = '0;
        fc_m = 16'd0;
        ec_m = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_hdr_valid", 64'(bus.hdr_valid), 64'd0);
        check("rst_fields", {bus.base_address, bus.phase_entropy_index, bus.complecount_trace,
              bus.fallback_vector, bus.somatic_coherence, bus.verbal_override}, 64'd0);
        check("rst_pulses", {bus.chk_err, bus.fmt_err, bus.timeout_err}, 64'd0);
        check("rst_counts", {bus.frame_count, bus.err_count}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor: every pulse or header arrival pops one expectation.
    logic hv_prev = 1'b0;
    logic rst_prev = 1'b1;
    logic [52:0] f_prev = '0;
    always @(negedge clk) begin : mon
        logic [52:0] f_now;
        int nev;
        int kind;
        exp_t e;
        f_now = {bus.base_address, bus.phase_entropy_index, bus.complecount_trace,
                 bus.fallback_vector, bus.somatic_coherence, bus.verbal_override};
        nev = 0;
        kind = -1;
        if (bus.hdr_valid === 1'b1 && !hv_prev) begin nev++; kind = K_GOOD; end
        if (bus.chk_err === 1'b1) begin nev++; kind = K_CHK; end
        if (bus.fmt_err === 1'b1) begin nev++; kind = K_FMT; end
        if (bus.timeout_err === 1'b1) begin nev++; kind = K_TMO; end
        if (!rst && !rst_prev) begin
            if (nev > 1) check("single_event", 64'(nev), 64'd1);
            if (nev >= 1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d, expected none", kind);
                end else begin
                    e = sb.pop_front();
                    check("ev_kind", 64'(kind), 64'(e.kind));
                    check("ev_fields", 64'(f_now), 64'(e.fields));
                    check("ev_frame_count", 64'(bus.frame_count), 64'(e.fc));
                    check("ev_err_count", 64'(bus.err_count), 64'(e.ec));
                end
            end else begin
                check("fields_stable", 64'(f_now), 64'(f_prev));
            end
        end
        hv_prev  = bus.hdr_valid;
        rst_prev = rst;
        f_prev   = f_now;
    end

    initial begin
        int lo;
        int hv;
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.hdr_ready = 1'b1;
        last_good = '0;
        fc_m = 16'd0;
        ec_m = 8'd0;
        fa       = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF5, 8'h3C, 8'hA8, 8'hCC};
        fa_bad   = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF5, 8'h3C, 8'hA8, 8'hCD};
        fb       = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'hFF, 8'h50, 8'h03};
        fields_a = pk(32'h12345678, 5'd30, 3'd5, 8'h3C, 4'd10, 1'b1);
        fields_b = pk(32'h00000001, 5'd1, 3'd0, 8'hFF, 4'd5, 1'b0);
        vecs[0] = mk(fa_bad, K_CHK, '0);
        vecs[1] = mk(fa, K_GOOD, fields_a);
        vecs[2] = mk({8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF5, 8'h3C, 8'hA9, 8'hCD}, K_FMT, '0);
        vecs[3] = mk({8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF5, 8'h3C, 8'hA9, 8'hCC}, K_CHK, '0);
        vecs[4] = mk(fb, K_GOOD, fields_b);
        vecs[5] = mk({8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, K_GOOD,
                     pk(32'hA5000000, 5'd0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs[6] = mk({8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00}, K_FMT, '0);
        vecs[7] = mk({8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hF8, 8'hA2}, K_GOOD,
                     pk(32'hFFFFFFFF, 5'd31, 3'd7, 8'h00, 4'd15, 1'b1));

        do_reset();

        foreach (vecs[i]) begin
            expect_ev(vecs[i].kind, vecs[i].fields);
            send_frame(vecs[i].b);
            repeat (3) @(negedge clk);
        end
        drain();

        // Latency and single-cycle hold with hdr_ready already high.
        expect_ev(K_GOOD, fields_a);
        send_frame(fa);
        check("latency_hdr_valid", 64'(bus.hdr_valid), 64'd1);
        lo = 0;
        hv = 0;
        for (int n = 0; n < 4; n++) begin
            if (!bus.in_ready) lo++;
            if (bus.hdr_valid) hv++;
            @(negedge clk);
        end
        check("in_ready_low_cycles", 64'(lo), 64'd1);
        check("hdr_valid_cycles", 64'(hv), 64'd1);

        // Garbage before sync is silently discarded.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        expect_ev(K_GOOD, fields_b);
        send_frame(fb);
        drain();

        // A 16-cycle mid-frame stall aborts; a 15-cycle stall does not.
        expect_ev(K_TMO, '0);
        for (int i = 0; i < 5; i++) send_byte(fa[i]);
        repeat (16) @(negedge clk);
        repeat (3) @(negedge clk);
        expect_ev(K_GOOD, fields_a);
        send_frame(fa);
        drain();
        expect_ev(K_GOOD, fields_b);
        for (int i = 0; i < 5; i++) send_byte(fb[i]);
        repeat (15) @(negedge clk);
        for (int i = 5; i < 9; i++) send_byte(fb[i]);
        drain();

        // Back-pressure: header is held while upstream keeps offering a byte.
        bus.hdr_ready = 1'b0;
        expect_ev(K_GOOD, fields_a);
        send_frame(fa);
        bus.in_byte  = 8'hA5;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_hdr_valid", 64'(bus.hdr_valid), 64'd1);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.hdr_ready = 1'b1;
        @(negedge clk);
        check("release_hdr_valid", 64'(bus.hdr_valid), 64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        expect_ev(K_GOOD, fields_b);
        send_frame(fb);
        drain();

        // Reset part-way through a frame, then a fresh good frame.
        for (int i = 0; i < 6; i++) send_byte(fa[i]);
        do_reset();
        expect_ev(K_GOOD, fields_a);
        send_frame(fa);
        drain();

        // err_count saturation.
        for (int k = 0; k < 256; k++) begin
            expect_ev(K_CHK, '0);
            send_frame(fa_bad);
        end
        drain();
        check("err_count_sat", 64'(bus.err_count), 64'd255);
        check("frame_count_after_sat", 64'(bus.frame_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spiral_header_deframer.md
# spiral_header_deframer

Byte-serial deframer that sits directly upstream of the SPIRAL coherence integration stage. It hunts for a sync byte, assembles a 9-byte consent header, and validates it with an XOR checksum and a reserved-bit check. It presents the decoded fields (phase entropy index, complecount trace, fallback vector, base address, raw somatic coherence and verbal override) on a valid/ready handshake. Malformed or stalled frames are dropped and counted; the field outputs never glitch.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker (byte 0).
- TIMEOUT_CYCLES, 16, idle cycles tolerated between bytes mid-frame, legal range 1..255.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  deframer accepts a byte this cycle.
- hdr_valid  out  1  decoded header available.
- hdr_ready  in  1  consumer takes header.
- base_address  out  32  bytes 1..4, big-endian.
- phase_entropy_index  out  5  byte 5 [7:3].
- complecount_trace  out  3  byte 5 [2:0].
- fallback_vector  out  8  byte 6.
- somatic_coherence  out  4  byte 7 [7:4].
- verbal_override  out  1  byte 7 [3].
- chk_err  out  1  one-cycle pulse: checksum mismatch.
- fmt_err  out  1  one-cycle pulse: byte 7 [2:0] nonzero.
- timeout_err  out  1  one-cycle pulse: mid-frame stall abort.
- frame_count  out  16  good frames committed, wraps at 65535→0.
- err_count  out  8  total dropped frames, saturates at 255.

## Operation
- Frame: byte0 = SYNC_BYTE, bytes 1..7 = payload, byte8 = XOR of bytes 0..7.
- Transfer occurs on an edge where in_valid && in_ready.
- States: HUNT, BODY, HOLD. Reset → HUNT.
- HUNT: in_ready=1. Accepted byte == SYNC_BYTE → BODY, byte index=1, running xor=SYNC_BYTE. Any other byte is discarded silently and is not counted.
- BODY: in_ready=1. Each accepted byte is stored to its shadow register at the current index, xor-accumulated, and the index is incremented. SYNC_BYTE inside BODY is ordinary data.
- On acceptance of byte 8:
  - If xor≠byte8: chk_err pulse, err_count+1, → HUNT.
  - Else if byte7[2:0]≠0: fmt_err pulse, err_count+1, → HUNT.
  - Else: field outputs load from the shadow registers, hdr_valid=1, frame_count+1, → HOLD.
- Checksum has priority over the format check. Exactly one error pulse and one err_count increment per bad frame.
- BODY idle counter: cleared on each accepted byte, incremented otherwise. On reaching TIMEOUT_CYCLES: timeout_err pulse, err_count+1, → HUNT, counter cleared. The counter is inactive in HUNT and HOLD.
- HOLD: in_ready=0, hdr_valid=1, and fields are stable. On hdr_valid && hdr_ready → HUNT, hdr_valid=0.
- Field outputs change only on a good-frame commit. They retain the last good header after hdr_valid drops.
- No consent-state derivation happens here; somatic_coherence and verbal_override pass raw to the consent deriver.

## Timing
- Reset (synchronous, rst=1 at an edge): state=HUNT, in_ready=1 the next cycle. All field outputs, hdr_valid, error pulses, frame_count, err_count, byte index, xor and idle counter are 0.
- rst mid-frame or in HOLD: a pending header is lost and counters are zeroed. No error pulse.
- Latency: hdr_valid is high the cycle after the edge accepting byte 8. Minimum frame-to-frame spacing is 9 transfers + 1 HOLD cycle when hdr_ready is held high.
- hdr_ready high with hdr_valid low has no effect.
- An error pulse is high the cycle after the edge accepting byte 8, or the cycle after the timeout edge.
- Simultaneous byte acceptance and idle counter reaching TIMEOUT_CYCLES: the byte wins, the counter clears, and there is no timeout.
- in_valid is ignored while in_ready=0; upstream holds the byte.
- Byte index range is 0..8 and never wraps; it resets to 0 on every return to HUNT.

## Test plan
- Good frame A5 12 34 56 78 F5 3C A8 CC, hdr_ready=1 → hdr_valid for 1 cycle, base_address=0x12345678, phase_entropy_index=30, complecount_trace=5, fallback_vector=0x3C, somatic_coherence=10, verbal_override=1, frame_count=1, in_ready low exactly 1 cycle.
- Same frame with byte8=CD → chk_err 1 pulse, err_count=1, fields remain 0, hdr_valid never high. An immediately following good frame is decoded.
- Byte7=A9 with corrected checksum CD → fmt_err pulse only, err_count=1. Byte7=A9 with checksum CC → chk_err only.
- Garbage 00 FF 3C then good frame → garbage discarded, no errors, header decoded. Stall 16 cycles after byte 4 → timeout_err pulse, then recovery on the next A5. Stall of 15 cycles then continuation → no timeout.
- Good frame with hdr_ready=0 for 20 cycles while in_valid=1 → in_ready=0, fields stable, no bytes consumed. Release → handshake, HUNT.
- Assert rst after byte 5 → all outputs 0, no error pulse. A subsequent good frame yields frame_count=1. Force 256 bad frames → err_count=255 saturated.
